mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous reset, active-low.
REQ-003 The block SHALL have port Cond, input, 4 bits: Instr[31:28].
REQ-004 The block SHALL have port Op, input, 2 bits: Instr[27:26], where 00 = data-processing (DP), 01 = memory, 10 = branch.
REQ-005 The block SHALL have port Funct, input, 6 bits: Instr[25:20], with [5] = I, [4:1] = cmd, [0] = S (DP) or L (memory).
REQ-006 The block SHALL have port Rd, input, 4 bits: Instr[15:12].
REQ-007 The block SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the ALU, same cycle.
REQ-008 The block SHALL have outputs IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, 1 bit each: datapath strobes and selects.
REQ-009 The block SHALL have outputs ALUSrcB, ResultSrc, ALUControl, 2 bits each.
REQ-010 The select encodings SHALL be:
- ALUSrcA: 0 = A, 1 = PC.
- ALUSrcB: 00 = reg, 01 = ExtImm, 10 = 4.
- ResultSrc: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- AdrSrc: 0 = PC, 1 = Result.
- ALUControl: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.

Function
REQ-011 The FSM SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH and UNKNOWN.
REQ-012 The FSM SHALL make these transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR if Op = 01; EXER if Op = 00 and I = 0; EXEI if Op = 00 and I = 1; BRANCH if Op = 10; otherwise UNKNOWN.
- MEMADR -> MEMRD if L = 1, else MEMWR.
- MEMRD -> MEMWB.
- EXER and EXEI -> ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN -> FETCH.
REQ-013 FETCH SHALL drive AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 10, ALU ADD, ResultSrc = 10, IRWrite = 1 and PCWrite = 1 (PC+4).
REQ-014 DECODE SHALL drive ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10 and ALU ADD (PC+8 for R15 reads), and SHALL latch condex from Cond and the stored flags.
REQ-015 MEMADR SHALL drive ALUSrcA = 0, ALUSrcB = 01 and ALU ADD.
REQ-016 MEMRD SHALL drive ResultSrc = 00 and AdrSrc = 1.
REQ-017 MEMWB SHALL drive ResultSrc = 01 and assert the register write.
REQ-018 MEMWR SHALL drive ResultSrc = 00 and AdrSrc = 1, and assert the memory write.
REQ-019 EXER SHALL drive ALUSrcA = 0, ALUSrcB = 00 and ALUControl from cmd; EXEI SHALL do the same with ALUSrcB = 01.
REQ-020 ALUWB SHALL drive ResultSrc = 00 and assert the register write.
REQ-021 BRANCH SHALL drive ALUSrcA = 0, ALUSrcB = 01, ALU ADD and ResultSrc = 10, and assert the branch strobe.
REQ-022 ALU decode for cmd SHALL be 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR, and any other value -> ADD; non-execute states SHALL use ADD.
REQ-023 Condition evaluation SHALL cover EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL using the stored flags; Cond = 1111 SHALL evaluate false.
REQ-024 The gated outputs SHALL be:
- RegWrite = regw_fsm & condex.
- MemWrite = memw_fsm & condex.
- PCWrite = FETCH | (condex & (BRANCH | (regw_fsm & Rd == 15))).
REQ-025 The stored flags {N,Z} SHALL update from ALUFlags at the clock edge ending EXER or EXEI when S = 1 and condex = 1.
REQ-026 The stored flags {C,V} SHALL update under the same conditions as REQ-025 only when cmd selects ADD or SUB.
REQ-027 A condition-failed instruction SHALL still traverse its full state sequence, with no register, memory, PC (beyond PC+4) or flag side effect.
REQ-028 Latencies SHALL be: DP 4 cycles, LDR 5, STR 4, B 3, undefined Op = 3 (UNKNOWN asserts no strobe).
REQ-029 All strobes SHALL be Moore outputs decoded from state, except for the condex and Rd gating of REQ-024.

Reset
REQ-030 reset low SHALL force state = FETCH, flags = 0000 and condex = 0 immediately, independent of clk.
REQ-031 The first rising clk edge after reset deasserts SHALL complete FETCH.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction with no further RegWrite or MemWrite.
REQ-033 While reset is low, outputs SHALL present FETCH decode.

Structure
REQ-034 The state enum, ALUControl codes, select encodings and condition-code constants SHALL reside in a shared package, mc_pkg.
REQ-035 Condition evaluation SHALL be a sub-module, mc_condcheck, taking Cond and flags and producing condex, pure combinational.

Verification
REQ-036 The bench SHALL apply ADD (Cond = 1110, Op = 00, Funct = 001000) and check FETCH, DECODE, EXER, ALUWB, with RegWrite = 1 in cycle 4 only and ALUControl = 00 in EXER.
REQ-037 The bench SHALL apply LDR (Op = 01, Funct = 011001) and check five cycles, with ResultSrc = 01 and RegWrite in MEMWB; Rd = 15 SHALL additionally assert PCWrite in MEMWB.
REQ-038 The bench SHALL apply SUBS from EXEI with ALUFlags = 0110, then BEQ (Cond = 0000), and check branch PCWrite = 1 in BRANCH.
REQ-039 The bench SHALL apply BNE after the same flags and check PCWrite = 0 in BRANCH, with the next FETCH following normally.
REQ-040 The bench SHALL apply STR (Op = 01, L = 0) with Cond = 0001 and Z = 1, and check MemWrite = 0 throughout with four cycles consumed.
REQ-041 The bench SHALL assert reset asynchronously during MEMRD and check state = FETCH, flags = 0000 and no RegWrite before the clock edge.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control sequencer: states, ALU codes,
// datapath select encodings, instruction field codes and condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXER,
        S_EXEI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic       SRCA_A        = 1'b0;
    localparam logic       SRCA_PC       = 1'b1;
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unlisted commands fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// Combinational condition-code evaluation against the stored flags.
// The reserved code 1111 evaluates false.
module mc_condcheck
    import mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  flags_t     flags_i,
    output logic       condex_o
);

    // NOTE: condex_o gets a default before the case so no latch is inferred.
    always_comb begin
        condex_o = 1'b0;
        case (cond_i)
            COND_EQ: condex_o = flags_i.z;
            COND_NE: condex_o = !flags_i.z;
            COND_CS: condex_o = flags_i.c;
            COND_CC: condex_o = !flags_i.c;
            COND_MI: condex_o = flags_i.n;
            COND_PL: condex_o = !flags_i.n;
            COND_VS: condex_o = flags_i.v;
            COND_VC: condex_o = !flags_i.v;
            COND_HI: condex_o = flags_i.c && !flags_i.z;
            COND_LS: condex_o = !flags_i.c || flags_i.z;
            COND_GE: condex_o = (flags_i.n == flags_i.v);
            COND_LT: condex_o = (flags_i.n != flags_i.v);
            COND_GT: condex_o = !flags_i.z && (flags_i.n == flags_i.v);
            COND_LE: condex_o = flags_i.z || (flags_i.n != flags_i.v);
            COND_AL: condex_o = 1'b1;
            default: condex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: Moore FSM driving datapath selects and strobes,
// with write strobes gated by the condition latched in DECODE.
module mc_sequencer
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl
);

    state_t state_q, state_d;
    flags_t flags_q, flags_d;
    logic   condex_q, condex_d;
    logic   cond_ok;
    logic   regw_fsm, memw_fsm, branch_fsm;
    logic   in_exe;

    mc_condcheck u_condcheck (
        .cond_i   (Cond),
        .flags_i  (flags_q),
        .condex_o (cond_ok)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:    state_d = S_MEMADR;
                    OP_DP:     state_d = Funct[5] ? S_EXEI : S_EXER;
                    OP_BRANCH: state_d = S_BRANCH;
                    default:   state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXER:   state_d = S_ALUWB;
            S_EXEI:   state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite    = 1'b0;
        AdrSrc     = ADR_PC;
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        regw_fsm   = 1'b0;
        memw_fsm   = 1'b0;
        branch_fsm = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = ADR_RESULT;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                regw_fsm  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = ADR_RESULT;
                memw_fsm = 1'b1;
            end
            S_EXER: ALUControl = alu_decode(Funct[4:1]);
            S_EXEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_decode(Funct[4:1]);
            end
            S_ALUWB: regw_fsm = 1'b1;
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                branch_fsm = 1'b1;
            end
            default: ;
        endcase
    end

    // A condition-failed instruction still walks its states but writes nothing.
    assign RegWrite = regw_fsm & condex_q;
    assign MemWrite = memw_fsm & condex_q;
    assign PCWrite  = (state_q == S_FETCH) |
                      (condex_q & (branch_fsm | (regw_fsm & (Rd == 4'd15))));

    assign in_exe = (state_q == S_EXER) || (state_q == S_EXEI);

    // C and V only carry meaning after an ADD or SUB, so logic ops keep them.
    always_comb begin
        flags_d  = flags_q;
        condex_d = condex_q;
        if (state_q == S_DECODE) condex_d = cond_ok;
        if (in_exe && Funct[0] && condex_q) begin
            flags_d.n = ALUFlags[3];
            flags_d.z = ALUFlags[2];
            if (Funct[4:1] == CMD_ADD || Funct[4:1] == CMD_SUB) begin
                flags_d.c = ALUFlags[1];
                flags_d.v = ALUFlags[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: an instruction-level model predicts the
// per-cycle control outputs, and directed literal checks pin key cycles.
module tb_mc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond     = 4'he;
    logic [1:0] Op       = 2'b00;
    logic [5:0] Funct    = 6'b0;
    logic [3:0] Rd       = 4'd0;
    logic [3:0] ALUFlags = 4'b0;
    logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl;

    always #5 clk = ~clk;

    mc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl)
    );

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXER, P_EXEI, P_ALUWB, P_BRANCH, P_UNKNOWN} phase_t;

    typedef struct packed {
        logic       irw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] alu;
        logic       pcw;
        logic       rw;
        logic       mw;
    } ov_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    exp_valid = 1'b0;
    ov_t   exp_vec, exp_mask;
    int    cyc_idx;
    string tag;
    ov_t   act_log [8];
    logic [3:0] m_flags;   // {N,Z,C,V}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ARM rule: even codes test a predicate, odd codes invert it; 1111 is AL inverted.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        if (cmd == 4'b0010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic void expect_for(input phase_t p, input bit cx, input logic [5:0] f,
                                       input logic [3:0] rd, output ov_t e, output ov_t m);
        e = '0;
        m = '0;
        m.irw = 1'b1; m.pcw = 1'b1; m.rw = 1'b1; m.mw = 1'b1; m.alu = 2'b11;
        case (p)
            P_FETCH: begin
                e.irw = 1; e.adr = 0; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1;
                m.adr = 1; m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
            end
            P_DECODE: begin
                e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
                m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
            end
            P_MEMADR: begin
                e.srca = 0; e.srcb = 2'b01;
                m.srca = 1; m.srcb = 2'b11;
            end
            P_MEMRD: begin
                e.res = 2'b00; e.adr = 1;
                m.res = 2'b11; m.adr = 1;
            end
            P_MEMWB: begin
                e.res = 2'b01; e.rw = cx; e.pcw = cx && (rd == 4'd15);
                m.res = 2'b11;
            end
            P_MEMWR: begin
                e.res = 2'b00; e.adr = 1; e.mw = cx;
                m.res = 2'b11; m.adr = 1;
            end
            P_EXER, P_EXEI: begin
                e.srca = 0; e.srcb = (p == P_EXEI) ? 2'b01 : 2'b00; e.alu = alu_of(f[4:1]);
                m.srca = 1; m.srcb = 2'b11;
            end
            P_ALUWB: begin
                e.res = 2'b00; e.rw = cx; e.pcw = cx && (rd == 4'd15);
                m.res = 2'b11;
            end
            P_BRANCH: begin
                e.srca = 0; e.srcb = 2'b01; e.res = 2'b10; e.pcw = cx;
                m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
            end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        ov_t a;
        if (exp_valid) begin
            a = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, PCWrite, RegWrite, MemWrite};
            act_log[cyc_idx] = a;
            check(tag, 32'(a & exp_mask), 32'(exp_vec & exp_mask));
        end
    end

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input string nm, input logic [3:0] c, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd, input logic [3:0] aluf);
        phase_t seq[$];
        bit  cx;
        ov_t e, m;
        cx = 1'b0;
        seq.push_back(P_FETCH);
        seq.push_back(P_DECODE);
        case (op)
            2'b00: begin
                seq.push_back(f[5] ? P_EXEI : P_EXER);
                seq.push_back(P_ALUWB);
            end
            2'b01: begin
                seq.push_back(P_MEMADR);
                if (f[0]) begin
                    seq.push_back(P_MEMRD);
                    seq.push_back(P_MEMWB);
                end else begin
                    seq.push_back(P_MEMWR);
                end
            end
            2'b10:   seq.push_back(P_BRANCH);
            default: seq.push_back(P_UNKNOWN);
        endcase
        Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = aluf;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == P_DECODE) cx = cond_holds(c, m_flags);
            expect_for(seq[i], cx, f, rd, e, m);
            exp_vec   = e;
            exp_mask  = m;
            cyc_idx   = i;
            tag       = $sformatf("%s/%s", nm, seq[i].name());
            exp_valid = 1'b1;
            @(posedge clk); #1;
            if ((seq[i] == P_EXER || seq[i] == P_EXEI) && f[0] && cx) begin
                m_flags[3:2] = aluf[3:2];
                if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) m_flags[1:0] = aluf[1:0];
            end
        end
        exp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        m_flags = 4'b0000;
        #2;
        check("rst_irwrite",  IRWrite,  1);
        check("rst_pcwrite",  PCWrite,  1);
        check("rst_regwrite", RegWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_alusrcb",  ALUSrcB,  2'b10);
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr("ADD", 4'b1110, 2'b00, 6'b001000, 4'd3, 4'b0000);
        for (int i = 0; i < 4; i++)
            check($sformatf("add_regwrite_c%0d", i + 1), act_log[i].rw, (i == 3) ? 1 : 0);
        check("add_exer_alucontrol", act_log[2].alu, 2'b00);

        run_instr("LDR", 4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
        check("ldr_memwb_resultsrc", act_log[4].res, 2'b01);
        check("ldr_memwb_regwrite",  act_log[4].rw,  1);
        check("ldr_memwb_pcwrite",   act_log[4].pcw, 0);

        run_instr("LDR_PC", 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
        check("ldrpc_memwb_pcwrite", act_log[4].pcw, 1);

        run_instr("SUBS_I", 4'b1110, 2'b00, 6'b100101, 4'd1, 4'b0110);
        check("subs_exei_alucontrol", act_log[2].alu,  2'b01);
        check("subs_exei_alusrcb",    act_log[2].srcb, 2'b01);

        run_instr("BEQ", 4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("beq_branch_pcwrite", act_log[2].pcw, 1);

        run_instr("BNE", 4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("bne_branch_pcwrite", act_log[2].pcw, 0);

        run_instr("STR_NE", 4'b0001, 2'b01, 6'b011000, 4'd5, 4'b0000);
        check("bne_next_fetch_irwrite", act_log[0].irw, 1);
        check("bne_next_fetch_pcwrite", act_log[0].pcw, 1);
        for (int i = 0; i < 4; i++)
            check($sformatf("strne_memwrite_c%0d", i + 1), act_log[i].mw, 0);

        run_instr("STR", 4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000);
        check("strne_then_fetch_irwrite", act_log[0].irw, 1);
        check("str_memwr_memwrite",       act_log[3].mw,  1);

        run_instr("ANDS", 4'b1110, 2'b00, 6'b000001, 4'd6, 4'b1001);
        check("ands_exer_alucontrol", act_log[2].alu, 2'b10);
        run_instr("BHI", 4'b1000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("bhi_branch_pcwrite", act_log[2].pcw, 1);
        run_instr("BVS", 4'b0110, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("bvs_branch_pcwrite", act_log[2].pcw, 0);

        run_instr("ORRSEQ", 4'b0000, 2'b00, 6'b011001, 4'd7, 4'b0100);
        check("orrseq_aluwb_regwrite", act_log[3].rw,  0);
        check("orrseq_exer_alucontrol", act_log[2].alu, 2'b11);
        run_instr("BMI", 4'b0100, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("bmi_branch_pcwrite", act_log[2].pcw, 1);

        run_instr("CMD_UNDEF", 4'b1110, 2'b00, 6'b011110, 4'd8, 4'b0000);
        check("cmdundef_alucontrol", act_log[2].alu, 2'b00);

        run_instr("OP_UNDEF", 4'b1110, 2'b11, 6'b000000, 4'd15, 4'b0000);
        check("opundef_pcwrite", act_log[2].pcw, 0);
        check("opundef_regwrite", act_log[2].rw, 0);

        run_instr("B_NV", 4'b1111, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("bnv_branch_pcwrite", act_log[2].pcw, 0);

        run_instr("SUBS_R", 4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0110);

        // Abort an LDR in MEMRD with an asynchronous reset between clock edges.
        Cond = 4'b1110; Op = 2'b01; Funct = 6'b011001; Rd = 4'd4;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_memrd_adrsrc",    AdrSrc,    1);
        check("abort_memrd_resultsrc", ResultSrc, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        m_flags = 4'b0000;
        check("abort_irwrite",  IRWrite,  1);
        check("abort_pcwrite",  PCWrite,  1);
        check("abort_regwrite", RegWrite, 0);
        check("abort_memwrite", MemWrite, 0);
        check("abort_adrsrc",   AdrSrc,   0);
        @(posedge clk); #1;
        check("abort_hold_irwrite",  IRWrite,  1);
        check("abort_hold_regwrite", RegWrite, 0);
        reset = 1'b1;

        run_instr("BEQ_AFTER_RST", 4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("rst_flags_beq_pcwrite", act_log[2].pcw, 0);
        run_instr("BCS_AFTER_RST", 4'b0010, 2'b10, 6'b000000, 4'd0, 4'b0000);
        check("rst_flags_bcs_pcwrite", act_log[2].pcw, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
